// File: rtl/fp32_mesh_pkg.sv
// fp32_mesh_pkg: PE state encoding and single-precision multiply/add used by the mesh PEs.
package fp32_mesh_pkg;
    typedef enum logic [1:0] {IDLE, MUL, ACC, READ} pe_state_e;
    localparam int BIAS = 127;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    function automatic logic [31:0] fp32_mul(input logic [31:0] x, input logic [31:0] y);
        logic s;
        logic [47:0] p;
        logic [23:0] m;
        logic g, st;
        int e;
        s = x[31] ^ y[31];
        if ((x[30:23] == 8'hFF && x[22:0] != '0) || (y[30:23] == 8'hFF && y[22:0] != '0)) return QNAN;
        if (x[30:23] == 8'hFF || y[30:23] == 8'hFF)
            return (x[30:23] == 8'd0 || y[30:23] == 8'd0) ? QNAN : {s, 8'hFF, 23'd0};
        if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return '0;
        p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
        e = int'(x[30:23]) + int'(y[30:23]) - BIAS;
        if (p[47]) begin
            m = {1'b0, p[46:24]};
            g = p[23];
            st = |p[22:0];
            e++;
        end else begin
            m = {1'b0, p[45:23]};
            g = p[22];
            st = |p[21:0];
        end
        m = m + 24'(g && (st || m[0]));
        if (m[23]) e++;
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] fp32_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] hi, lo;
        logic [26:0] a, b;
        logic [27:0] s;
        logic [24:0] m;
        int e, d;
        if ((x[30:23] == 8'hFF && x[22:0] != '0) || (y[30:23] == 8'hFF && y[22:0] != '0)) return QNAN;
        if (x[30:23] == 8'hFF) return (y[30:23] == 8'hFF && x[31] != y[31]) ? QNAN : x;
        if (y[30:23] == 8'hFF) return y;
        if (x[30:23] == 8'd0) return (y[30:23] == 8'd0) ? {x[31] & y[31], 31'd0} : y;
        if (y[30:23] == 8'd0) return x;
        {hi, lo} = (x[30:0] >= y[30:0]) ? {x, y} : {y, x};
        e = int'(hi[30:23]);
        d = e - int'(lo[30:23]);
        a = {1'b1, hi[22:0], 3'b000};
        b = {1'b1, lo[22:0], 3'b000};
        // bits shifted out of the smaller operand collapse into a sticky LSB
        b = (d > 26) ? 27'd1 : ((b >> d) | 27'(|(b & ~({27{1'b1}} << d))));
        s = (hi[31] == lo[31]) ? 28'(a) + 28'(b) : 28'(a) - 28'(b);
        if (s == '0) return '0;
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e++;
        end
        for (int k = 0; k < 26; k++)
            if (!s[26]) begin
                s = s << 1;
                e--;
            end
        m = 25'(s[26:3]) + 25'(s[2] && (s[3] || (|s[1:0])));
        if (m[24]) e++;
        if (e >= 255) return {hi[31], 8'hFF, 23'd0};
        if (e <= 0) return {hi[31], 31'd0};
        return {hi[31], 8'(e), m[22:0]};
    endfunction
endpackage

// File: rtl/fp32_mesh_pe.sv
// fp32_mesh_pe: one output-stationary MAC cell with operand forwarding and accumulator readout.
module fp32_mesh_pe
    import fp32_mesh_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        select,
    input  logic [31:0] west,
    input  logic [31:0] north,
    output logic [31:0] east,
    output logic [31:0] south,
    output logic        pass_valid,
    output logic        acc_valid
);
    pe_state_e state, state_nxt;
    logic [31:0] a, b, prod, acc, east_q;

    always_comb begin
        state_nxt = IDLE;
        if (state == IDLE) state_nxt = in_valid ? MUL : (select ? READ : IDLE);
        else if (state == MUL) state_nxt = ACC;
        else if (state == READ && select) state_nxt = READ;
    end

    assign acc_valid = state == READ;
    assign east = acc_valid ? acc : east_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            a <= '0;
            b <= '0;
            prod <= '0;
            acc <= '0;
            east_q <= '0;
            south <= '0;
            pass_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            pass_valid <= state == ACC;
            if (state == IDLE && in_valid) begin
                a <= west;
                b <= north;
            end
            if (state == MUL) prod <= fp32_mul(a, b);
            if (state == ACC) begin
                acc <= fp32_add(acc, prod);
                east_q <= a;
                south <= b;
            end
        end
endmodule

// File: rtl/fp32_systolic_mesh.sv
// fp32_systolic_mesh: N x N grid of FP32 MAC cells; data ripples east, weights ripple south.
module fp32_systolic_mesh #(
    parameter int N = 3,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [DATA_WIDTH-1:0] north_i [N],
    input  logic [DATA_WIDTH-1:0] west_i [N],
    input  logic                  inputs_valid_i,
    input  logic                  select_accumulator_i [N][N],
    output logic [DATA_WIDTH-1:0] south_o [N],
    output logic [DATA_WIDTH-1:0] east_o [N],
    output logic                  passthrough_valid_o [N][N],
    output logic                  accumulator_valid_o [N][N]
);
    logic [DATA_WIDTH-1:0] east_w [N][N];
    logic [DATA_WIDTH-1:0] south_w [N][N];

    for (genvar r = 0; r < N; r++) begin : g_r
        for (genvar c = 0; c < N; c++) begin : g_c
            logic v;
            logic [DATA_WIDTH-1:0] w, n;
            if (c == 0) begin : g_w0
                assign w = west_i[r];
            end else begin : g_wn
                assign w = east_w[r][c-1];
            end
            if (r == 0) begin : g_n0
                assign n = north_i[c];
            end else begin : g_nn
                assign n = south_w[r-1][c];
            end
            if (c > 0) begin : g_vw
                assign v = passthrough_valid_o[r][c-1];
            end else if (r > 0) begin : g_vn
                assign v = passthrough_valid_o[r-1][c];
            end else begin : g_v0
                assign v = inputs_valid_i;
            end
            fp32_mesh_pe u_pe (
                .clk        (clk_i),
                .rst_n      (rstn_i),
                .in_valid   (v),
                .select     (select_accumulator_i[r][c]),
                .west       (w),
                .north      (n),
                .east       (east_w[r][c]),
                .south      (south_w[r][c]),
                .pass_valid (passthrough_valid_o[r][c]),
                .acc_valid  (accumulator_valid_o[r][c])
            );
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_o
        assign east_o[k] = east_w[k][N-1];
        assign south_o[k] = south_w[N-1][k];
    end
endmodule

// File: tb/tb_fp32_systolic_mesh.sv
// tb_fp32_systolic_mesh: directed scenarios for the 3x3 FP32 output-stationary mesh.
module tb_fp32_systolic_mesh;
    logic clk = 1'b0;
    logic rstn_i = 1'b0;
    logic valid = 1'b0;
    logic [31:0] north [3], west [3], south [3], east [3];
    logic sel [3][3], pv [3][3], av [3][3];
    logic [31:0] pe_east [3][3];
    logic [31:0] fv [10] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
    int vectors = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp32_systolic_mesh #(.N(3), .DATA_WIDTH(32)) dut (
        .clk_i                (clk),
        .rstn_i               (rstn_i),
        .north_i              (north),
        .west_i               (west),
        .inputs_valid_i       (valid),
        .select_accumulator_i (sel),
        .south_o              (south),
        .east_o               (east),
        .passthrough_valid_o  (pv),
        .accumulator_valid_o  (av)
    );

    assign pe_east[0][0] = dut.g_r[0].g_c[0].u_pe.east;
    assign pe_east[0][1] = dut.g_r[0].g_c[1].u_pe.east;
    assign pe_east[0][2] = dut.g_r[0].g_c[2].u_pe.east;
    assign pe_east[1][0] = dut.g_r[1].g_c[0].u_pe.east;
    assign pe_east[1][1] = dut.g_r[1].g_c[1].u_pe.east;
    assign pe_east[1][2] = dut.g_r[1].g_c[2].u_pe.east;
    assign pe_east[2][0] = dut.g_r[2].g_c[0].u_pe.east;
    assign pe_east[2][1] = dut.g_r[2].g_c[1].u_pe.east;
    assign pe_east[2][2] = dut.g_r[2].g_c[2].u_pe.east;

    task automatic do_reset();
        rstn_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn_i = 1'b1;
    endtask

    task automatic run_step(input logic [31:0] w [3], input logic [31:0] n [3], output logic done);
        west = w;
        north = n;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        done = 1'b0;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            done = pv[2][2];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic read_pe(input int i, input int j, output logic v, output logic [31:0] val);
        sel[i][j] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v = av[i][j];
        val = (j == 2) ? east[i] : pe_east[i][j];
        sel[i][j] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic v;
        logic [31:0] val;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            vectors += 2;
            if (south[i] !== 32'h0) begin errors++; $display("FAIL reset south_o[%0d]: got %h want 00000000", i, south[i]); end
            if (east[i] !== 32'h0) begin errors++; $display("FAIL reset east_o[%0d]: got %h want 00000000", i, east[i]); end
            for (int j = 0; j < 3; j++) begin
                vectors += 2;
                if (pv[i][j] !== 1'b0) begin errors++; $display("FAIL reset pv[%0d][%0d]: got %b want 0", i, j, pv[i][j]); end
                if (av[i][j] !== 1'b0) begin errors++; $display("FAIL reset av[%0d][%0d]: got %b want 0", i, j, av[i][j]); end
            end
        end
        @(posedge clk);
        #1 rstn_i = 1'b1;
        read_pe(1, 1, v, val);
        vectors++;
        if (v !== 1'b1 || val !== 32'h0) begin
            errors++;
            $display("FAIL reset_read pe[1][1]: got valid=%b val=%h want valid=1 val=00000000", v, val);
        end
    endtask

    task automatic test_identity();
        logic [31:0] w [3], n [3];
        logic done, v;
        logic [31:0] val;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) begin
                w[i] = fv[3*i+k+1];
                n[i] = (i == k) ? fv[1] : fv[0];
            end
            run_step(w, n, done);
            vectors++;
            if (done !== 1'b1) begin errors++; $display("FAIL identity step%0d timeout: got no pv[2][2] want pulse", k); end
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                read_pe(i, j, v, val);
                vectors++;
                if (v !== 1'b1 || val !== fv[3*i+j+1]) begin
                    errors++;
                    $display("FAIL identity C[%0d][%0d]: got valid=%b val=%h want valid=1 val=%h", i, j, v, val, fv[3*i+j+1]);
                end
            end
    endtask

    task automatic test_back_to_back();
        int am [3][3] = '{'{3, 2, 1}, '{6, 5, 4}, '{9, 8, 7}};
        int bm [3][3] = '{'{2, 4, 6}, '{1, 3, 5}, '{7, 8, 9}};
        logic [31:0] cm [3][3] = '{'{32'h41700000, 32'h41D00000, 32'h42140000},
                                   '{32'h42340000, 32'h428E0000, 32'h42C20000},
                                   '{32'h42960000, 32'h42E80000, 32'h431D0000}};
        logic [31:0] w [3], n [3];
        logic done, v;
        logic [31:0] val;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) begin
                w[i] = fv[am[i][k]];
                n[i] = fv[bm[k][i]];
            end
            run_step(w, n, done);
            vectors++;
            if (done !== 1'b1) begin errors++; $display("FAIL matmul step%0d timeout: got no pv[2][2] want pulse", k); end
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                read_pe(i, j, v, val);
                vectors++;
                if (v !== 1'b1 || val !== cm[i][j]) begin
                    errors++;
                    $display("FAIL matmul C[%0d][%0d]: got valid=%b val=%h want valid=1 val=%h", i, j, v, val, cm[i][j]);
                end
            end
    endtask

    task automatic test_wavefront();
        logic [31:0] w [3] = '{32'h40000000, 32'h40400000, 32'h40800000};
        logic [31:0] n [3] = '{32'h3F800000, 32'h40A00000, 32'h40C00000};
        do_reset();
        west = w;
        north = n;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            vectors += 2;
            if (pv[0][0] !== 1'(k == 3)) begin errors++; $display("FAIL wave pv[0][0] cycle %0d: got %b want %b", k, pv[0][0], k == 3); end
            if (pv[2][2] !== 1'(k == 15)) begin errors++; $display("FAIL wave pv[2][2] cycle %0d: got %b want %b", k, pv[2][2], k == 15); end
        end
        for (int i = 0; i < 3; i++) begin
            vectors += 2;
            if (south[i] !== n[i]) begin errors++; $display("FAIL wave south_o[%0d]: got %h want %h", i, south[i], n[i]); end
            if (east[i] !== w[i]) begin errors++; $display("FAIL wave east_o[%0d]: got %h want %h", i, east[i], w[i]); end
        end
    endtask

    task automatic test_readout_hold();
        sel[1][2] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (av[1][2] !== 1'b1 || east[1] !== 32'h41900000) begin
                errors++;
                $display("FAIL hold cycle %0d: got valid=%b east_o[1]=%h want valid=1 east_o[1]=41900000", c, av[1][2], east[1]);
            end
        end
        sel[1][2] = 1'b0;
        @(negedge clk);
        vectors++;
        if (av[1][2] !== 1'b0 || east[1] !== 32'h40400000) begin
            errors++;
            $display("FAIL hold release: got valid=%b east_o[1]=%h want valid=0 east_o[1]=40400000", av[1][2], east[1]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_busy_select();
        do_reset();
        west = '{32'h40000000, 32'h40400000, 32'h40800000};
        north = '{32'h3F800000, 32'h40A00000, 32'h40C00000};
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (12) @(posedge clk);
        #1 sel[2][2] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (av[2][2] !== 1'b0) begin errors++; $display("FAIL busy held-off cycle %0d: got valid=%b want 0", c, av[2][2]); end
        end
        vectors++;
        if (pv[2][2] !== 1'b1) begin errors++; $display("FAIL busy pv[2][2]: got %b want 1", pv[2][2]); end
        @(negedge clk);
        vectors++;
        if (av[2][2] !== 1'b1 || east[2] !== 32'h41C00000) begin
            errors++;
            $display("FAIL busy readout: got valid=%b east_o[2]=%h want valid=1 east_o[2]=41C00000", av[2][2], east[2]);
        end
        sel[2][2] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_step();
        logic v;
        logic [31:0] val;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rstn_i = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            vectors += 2;
            if (south[i] !== 32'h0) begin errors++; $display("FAIL midreset south_o[%0d]: got %h want 00000000", i, south[i]); end
            if (east[i] !== 32'h0) begin errors++; $display("FAIL midreset east_o[%0d]: got %h want 00000000", i, east[i]); end
            for (int j = 0; j < 3; j++) begin
                vectors += 2;
                if (pv[i][j] !== 1'b0) begin errors++; $display("FAIL midreset pv[%0d][%0d]: got %b want 0", i, j, pv[i][j]); end
                if (av[i][j] !== 1'b0) begin errors++; $display("FAIL midreset av[%0d][%0d]: got %b want 0", i, j, av[i][j]); end
            end
        end
        repeat (2) @(posedge clk);
        #1 rstn_i = 1'b1;
        read_pe(0, 0, v, val);
        vectors++;
        if (v !== 1'b1 || val !== 32'h0) begin errors++; $display("FAIL midreset read pe[0][0]: got valid=%b val=%h want valid=1 val=00000000", v, val); end
        read_pe(2, 2, v, val);
        vectors++;
        if (v !== 1'b1 || val !== 32'h0) begin errors++; $display("FAIL midreset read pe[2][2]: got valid=%b val=%h want valid=1 val=00000000", v, val); end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            north[i] = '0;
            west[i] = '0;
            for (int j = 0; j < 3; j++) sel[i][j] = 1'b0;
        end
        test_reset();
        test_identity();
        test_back_to_back();
        test_wavefront();
        test_readout_hold();
        test_busy_select();
        test_reset_mid_step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want summary before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
